rsa_word_sequencer: RTL and testbench

Upstream feeder for the `exponent_modulus` core. It accepts message words from a valid/ready stream and latches the key (modulus, exponent) at acceptance. It issues exactly one start pulse per word to the core, waits for the core's result, and presents the result on a valid/ready output stream. Out-of-range words and core timeouts are flagged with an error bit and never hang the stream.

---
 rtl/rsa_word_sequencer.sv | 111 +++++++++++
 tb/tb_rsa_word_sequencer.sv | 496 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_word_sequencer.sv
// Feeds message words one at a time into the exponent_modulus core, with range and timeout errors.
// Optional RSASEQ_DECRYPT_EN adds mode_in/exp_d_in to pick the private exponent per word.
module rsa_word_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] in_data_in,
  input  logic             in_valid_in,
  output logic             in_ready_out,
  input  logic [WIDTH-1:0] modulus_in,
  input  logic [WIDTH-1:0] exp_e_in,
`ifdef RSASEQ_DECRYPT_EN
  input  logic             mode_in,
  input  logic [WIDTH-1:0] exp_d_in,
`endif
  output logic             core_ready_out,
  output logic [WIDTH-1:0] core_value_out,
  output logic [WIDTH-1:0] core_modulus_out,
  output logic [WIDTH-1:0] core_exponent_out,
  input  logic [WIDTH-1:0] core_result_in,
  input  logic             core_busy_in,
  input  logic             core_valid_in,
  output logic [WIDTH-1:0] out_data_out,
  output logic             out_err_out,
  output logic             out_valid_out,
  input  logic             out_ready_in
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] exp_sel;
  logic             accept;
  logic             bad;

`ifdef RSASEQ_DECRYPT_EN
  assign exp_sel = mode_in ? exp_d_in : exp_e_in;
`else
  assign exp_sel = exp_e_in;
`endif

  // The core is never started on a word it cannot legally reduce.
  assign bad = (in_data_in >= modulus_in) ||
               (modulus_in < WIDTH'(2));

  assign in_ready_out   = !rst_in && (state == IDLE) &&
                          !core_busy_in;
  assign accept         = in_valid_in && in_ready_out;
  assign core_ready_out = (state == ISSUE);
  assign out_valid_out  = (state == HOLD);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= IDLE;
      cnt               <= '0;
      core_value_out    <= '0;
      core_modulus_out  <= '0;
      core_exponent_out <= '0;
      out_data_out      <= '0;
      out_err_out       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            core_value_out    <= in_data_in;
            core_modulus_out  <= modulus_in;
            core_exponent_out <= exp_sel;
            if (bad) begin
              out_data_out <= '0;
              out_err_out  <= 1'b1;
              state        <= HOLD;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + CW'(1);
          // A result arriving on the final cycle still counts.
          if (core_valid_in) begin
            out_data_out <= core_result_in;
            out_err_out  <= 1'b0;
            state        <= HOLD;
          end else if (cnt == LAST) begin
            out_data_out <= '0;
            out_err_out  <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_word_sequencer.sv
// Directed bench for rsa_word_sequencer with a behavioural modexp core.
// A second instance with TIMEOUT=16 exercises the timeout path.
module tb_rsa_word_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic [15:0] modulus = '0;
  logic [15:0] exp_e = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        core_ready;
  logic [15:0] core_value, core_mod, core_exp;
  logic [15:0] core_result;
  logic        core_busy = 1'b0;
  logic        core_valid = 1'b0;
  logic [15:0] out_data;
  logic        out_err, out_valid;
  logic        out_ready = 1'b0;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic        core_ready2;
  logic [15:0] core_value2, core_mod2, core_exp2;
  logic [15:0] core_result2 = '0;
  logic        core_busy2 = 1'b0;
  logic        core_valid2 = 1'b0;
  logic [15:0] out_data2;
  logic        out_err2, out_valid2;
  logic        out_ready2 = 1'b0;
`ifdef RSASEQ_DECRYPT_EN
  logic        mode = 1'b0;
  logic [15:0] exp_d = '0;
`endif

  int n_tests = 0;
  int n_fail = 0;

  int          mdl_cnt = 0;
  logic [15:0] mdl_res = '0;
  int          pulses = 0;

  always #5 clk = ~clk;

  rsa_word_sequencer #(.WIDTH(16)) dut (
    .clk_in(clk), .rst_in(rst),
    .in_data_in(in_data), .in_valid_in(in_valid),
    .in_ready_out(in_ready),
    .modulus_in(modulus), .exp_e_in(exp_e),
`ifdef RSASEQ_DECRYPT_EN
    .mode_in(mode), .exp_d_in(exp_d),
`endif
    .core_ready_out(core_ready), .core_value_out(core_value),
    .core_modulus_out(core_mod), .core_exponent_out(core_exp),
    .core_result_in(core_result), .core_busy_in(core_busy),
    .core_valid_in(core_valid),
    .out_data_out(out_data), .out_err_out(out_err),
    .out_valid_out(out_valid), .out_ready_in(out_ready)
  );

  rsa_word_sequencer #(.WIDTH(16), .TIMEOUT(16)) dut_to (
    .clk_in(clk), .rst_in(rst),
    .in_data_in(in_data), .in_valid_in(in_valid2),
    .in_ready_out(in_ready2),
    .modulus_in(modulus), .exp_e_in(exp_e),
`ifdef RSASEQ_DECRYPT_EN
    .mode_in(mode), .exp_d_in(exp_d),
`endif
    .core_ready_out(core_ready2), .core_value_out(core_value2),
    .core_modulus_out(core_mod2), .core_exponent_out(core_exp2),
    .core_result_in(core_result2), .core_busy_in(core_busy2),
    .core_valid_in(core_valid2),
    .out_data_out(out_data2), .out_err_out(out_err2),
    .out_valid_out(out_valid2), .out_ready_in(out_ready2)
  );

  function automatic logic [15:0] modexp(input logic [15:0] b,
                                         input logic [15:0] e,
                                         input logic [15:0] m);
    longint r, x;
    if (m == 0) return '0;
    r = 1 % m;
    x = b % m;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * x) % m;
      x = (x * x) % m;
    end
    return r[15:0];
  endfunction

  // Behavioural core: busy for 20 cycles, then a one-cycle valid.
  assign core_result = mdl_res;
  always @(posedge clk) begin
    core_valid <= 1'b0;
    if (core_ready) pulses <= pulses + 1;
    if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        core_valid <= 1'b1;
        core_busy  <= 1'b0;
      end
    end else if (core_ready) begin
      core_busy <= 1'b1;
      mdl_cnt   <= 20;
      mdl_res   <= modexp(core_value, core_exp, core_mod);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output bit ok, output bit vp);
    ok = 1'b0;
    vp = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      vp = core_valid;
      step();
      ok = out_valid;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if (in_ready !== 1'b0 || core_ready !== 1'b0 ||
        out_valid !== 1'b0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: rdy=%b crdy=%b ov=%b err=%b want 0000",
               in_ready, core_ready, out_valid, out_err);
    end
    n_tests++;
    if (core_value !== 16'd0 || core_mod !== 16'd0 ||
        core_exp !== 16'd0 || out_data !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_data: v=%0d m=%0d e=%0d d=%0d want 0",
               core_value, core_mod, core_exp, out_data);
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_nominal();
    bit ok, vp;
    int p0;
    p0 = pulses;
    modulus = 16'd1073;
    exp_e = 16'd10;
    in_data = 16'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    modulus = 16'd999;
    n_tests++;
    if (core_ready !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_issue: crdy=%b rdy=%b want 1 0",
               core_ready, in_ready);
    end
    n_tests++;
    if (core_value !== 16'd2 || core_exp !== 16'd10) begin
      n_fail++;
      $display("FAIL nom_latch: v=%0d e=%0d want 2 10",
               core_value, core_exp);
    end
    step();
    n_tests++;
    if (core_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_pulse_width: got %b want 0", core_ready);
    end
    wait_out(ok, vp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL nom_wait: got no out_valid want 1");
    end
    n_tests++;
    if (vp !== 1'b1) begin
      n_fail++;
      $display("FAIL nom_latency: core_valid before rise %b want 1", vp);
    end
    n_tests++;
    if (out_data !== 16'd1024 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_result: d=%0d err=%b want 1024 0",
               out_data, out_err);
    end
    n_tests++;
    if (pulses - p0 != 1 || core_mod !== 16'd1073) begin
      n_fail++;
      $display("FAIL nom_pulses: n=%0d mod=%0d want 1 1073",
               pulses - p0, core_mod);
    end
    handshake();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_release: ov=%b want 0", out_valid);
    end
  endtask

  task automatic test_range();
    bit ok, vp;
    int p0;
    p0 = pulses;
    modulus = 16'd1073;
    in_data = 16'd1073;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 ||
        out_data !== 16'd0 || core_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL range_eq: ov=%b err=%b d=%0d crdy=%b want 1 1 0 0",
               out_valid, out_err, out_data, core_ready);
    end
    step();
    step();
    n_tests++;
    if (pulses != p0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL range_nostart: pulses=%0d ov=%b want 0 1",
               pulses - p0, out_valid);
    end
    handshake();
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL range_idle: rdy=%b want 1", in_ready);
    end
    modulus = 16'd1;
    in_data = 16'd0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || core_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL range_mod1: ov=%b err=%b crdy=%b want 1 1 0",
               out_valid, out_err, core_ready);
    end
    handshake();
    modulus = 16'd1073;
    exp_e = 16'd1;
    in_data = 16'd1072;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_tests++;
    if (core_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL range_edge_ok: crdy=%b ov=%b want 1 0",
               core_ready, out_valid);
    end
    wait_out(ok, vp);
    n_tests++;
    if (!ok || out_data !== 16'd1072 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL range_edge_res: ok=%b d=%0d err=%b want 1 1072 0",
               ok, out_data, out_err);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    bit ok, vp, bad;
    modulus = 16'd1073;
    exp_e = 16'd2;
    in_data = 16'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(ok, vp);
    n_tests++;
    if (!ok || out_data !== 16'd9 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_result: ok=%b d=%0d err=%b want 1 9 0",
               ok, out_data, out_err);
    end
    in_data = 16'd5;
    exp_e = 16'd1;
    in_valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (out_valid !== 1'b1 || out_data !== 16'd9 ||
          in_ready !== 1'b0 || core_ready !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad || core_exp !== 16'd2) begin
      n_fail++;
      $display("FAIL bp_hold: ov=%b d=%0d rdy=%b e=%0d want 1 9 0 2",
               out_valid, out_data, in_ready, core_exp);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_idle: ov=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    step();
    in_valid = 1'b0;
    n_tests++;
    if (core_ready !== 1'b1 || core_value !== 16'd5) begin
      n_fail++;
      $display("FAIL bp_next_accept: crdy=%b v=%0d want 1 5",
               core_ready, core_value);
    end
    wait_out(ok, vp);
    n_tests++;
    if (!ok || out_data !== 16'd5) begin
      n_fail++;
      $display("FAIL bp_next_res: ok=%b d=%0d want 1 5", ok, out_data);
    end
    handshake();
  endtask

  task automatic test_timeout();
    bit bad;
    modulus = 16'd1073;
    exp_e = 16'd10;
    in_data = 16'd2;
    in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    n_tests++;
    if (core_ready2 !== 1'b1) begin
      n_fail++;
      $display("FAIL to_issue: crdy=%b want 1", core_ready2);
    end
    step();
    bad = 1'b0;
    for (int k = 1; k < 16; k++) begin
      step();
      if (out_valid2 !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL to_early: out_valid before 16 cycles want 0");
    end
    step();
    n_tests++;
    if (out_valid2 !== 1'b1 || out_err2 !== 1'b1 || out_data2 !== 16'd0) begin
      n_fail++;
      $display("FAIL to_flag: ov=%b err=%b d=%0d want 1 1 0",
               out_valid2, out_err2, out_data2);
    end
    out_ready2 = 1'b1;
    step();
    out_ready2 = 1'b0;
    core_result2 = 16'd55;
    core_valid2 = 1'b1;
    step();
    core_valid2 = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL to_late: ov=%b rdy=%b want 0 1", out_valid2, in_ready2);
    end
    in_data = 16'd4;
    in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    step();
    for (int k = 1; k < 16; k++) step();
    core_result2 = 16'd77;
    core_valid2 = 1'b1;
    step();
    core_valid2 = 1'b0;
    n_tests++;
    if (out_valid2 !== 1'b1 || out_err2 !== 1'b0 || out_data2 !== 16'd77) begin
      n_fail++;
      $display("FAIL to_valid_wins: ov=%b err=%b d=%0d want 1 0 77",
               out_valid2, out_err2, out_data2);
    end
    out_ready2 = 1'b1;
    step();
    out_ready2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit bad;
    int p0;
    modulus = 16'd1073;
    exp_e = 16'd10;
    in_data = 16'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || core_value !== 16'd0 ||
        core_mod !== 16'd0 || out_data !== 16'd0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_reset: rdy=%b ov=%b v=%0d m=%0d d=%0d want 0",
               in_ready, out_valid, core_value, core_mod, out_data);
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (core_busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_busy: busy=%b rdy=%b want 1 0", core_busy, in_ready);
    end
    p0 = pulses;
    bad = 1'b0;
    for (int i = 0; i < 40 && core_busy; i++) begin
      step();
      if (out_valid !== 1'b0 || in_ready !== !core_busy) bad = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
    end
    n_tests++;
    if (bad || core_busy !== 1'b0 || pulses != p0) begin
      n_fail++;
      $display("FAIL rmid_drain: ov=%b rdy=%b busy=%b want 0 1 0",
               out_valid, in_ready, core_busy);
    end
  endtask

`ifdef RSASEQ_DECRYPT_EN
  task automatic test_decrypt();
    bit ok, vp;
    modulus = 16'd1073;
    exp_e = 16'd3;
    exp_d = 16'd10;
    in_data = 16'd2;
    mode = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    mode = 1'b0;
    wait_out(ok, vp);
    n_tests++;
    if (!ok || out_data !== 16'd1024 || core_exp !== 16'd10) begin
      n_fail++;
      $display("FAIL dec_mode1: ok=%b d=%0d e=%0d want 1 1024 10",
               ok, out_data, core_exp);
    end
    handshake();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(ok, vp);
    n_tests++;
    if (!ok || out_data !== 16'd8) begin
      n_fail++;
      $display("FAIL dec_mode0: ok=%b d=%0d want 1 8", ok, out_data);
    end
    handshake();
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_range();
    test_backpressure();
    test_timeout();
    test_reset_mid();
`ifdef RSASEQ_DECRYPT_EN
    test_decrypt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
